// File: rtl/fpu_div_sched.sv
// rtl/fpu_div_sched.sv - single-entry issue/writeback scheduler for a fixed-latency iterative fdiv/fsqrt core
module fpu_div_sched #(
    parameter int LAT = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        IN_branchValid,
    input  logic [6:0]  IN_branchSqN,
    input  logic        IN_valid,
    input  logic        IN_opDiv,
    input  logic [31:0] IN_srcA,
    input  logic [31:0] IN_srcB,
    input  logic [6:0]  IN_sqN,
    input  logic [6:0]  IN_tagDst,
    input  logic [4:0]  IN_nmDst,
    output logic        OUT_ready,
    output logic        DIV_start,
    output logic        DIV_opDiv,
    output logic [31:0] DIV_a,
    output logic [31:0] DIV_b,
    input  logic [31:0] DIV_result,
    input  logic [4:0]  DIV_flags,
    input  logic        WB_grant,
    output logic        OUT_valid,
    output logic [31:0] OUT_result,
    output logic [4:0]  OUT_flags,
    output logic [6:0]  OUT_sqN,
    output logic [6:0]  OUT_tagDst,
    output logic [4:0]  OUT_nmDst
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [5:0] CNT_LOAD = 6'(LAT - 1);

    // Younger-than-branch test on wrapping 7-bit sequence numbers.
    function automatic logic squash_fn(input logic flush, input logic [6:0] sqn,
                                       input logic [6:0] br);
        logic [6:0] diff;
        diff = sqn - br;
        return flush && !diff[6] && (diff != 7'd0);
    endfunction

    state_t      state;
    logic [5:0]  cnt;
    logic        op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        accept;
    logic        flush_inflight;

    assign accept         = (state == IDLE) && en && IN_valid &&
                            !squash_fn(IN_branchValid, IN_sqN, IN_branchSqN);
    assign flush_inflight = squash_fn(IN_branchValid, OUT_sqN, IN_branchSqN);

    // The start pulse is combinational so the core sees operands in the accept cycle.
    assign DIV_start = accept && rst;
    assign DIV_opDiv = accept ? IN_opDiv : op_q;
    assign DIV_a     = accept ? IN_srcA  : a_q;
    assign DIV_b     = accept ? IN_srcB  : b_q;
    assign OUT_ready = (state == IDLE);
    assign OUT_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= 6'd0;
            op_q       <= 1'b0;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            OUT_result <= 32'd0;
            OUT_flags  <= 5'd0;
            OUT_sqN    <= 7'd0;
            OUT_tagDst <= 7'd0;
            OUT_nmDst  <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q       <= IN_opDiv;
                        a_q        <= IN_srcA;
                        b_q        <= IN_srcB;
                        OUT_sqN    <= IN_sqN;
                        OUT_tagDst <= IN_tagDst;
                        OUT_nmDst  <= IN_nmDst;
                        cnt        <= CNT_LOAD;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (flush_inflight) begin
                        cnt   <= 6'd0;
                        state <= IDLE;
                    end else if (cnt == 6'd0) begin
                        OUT_result <= DIV_result;
                        OUT_flags  <= DIV_flags;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt - 6'd1;
                    end
                end
                DONE: begin
                    if (flush_inflight || WB_grant) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_div_sched.sv
// tb/tb_fpu_div_sched.sv - randomized and directed checks of fpu_div_sched against a time-based model
module tb_fpu_div_sched;
    localparam int LAT = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0, IN_branchValid = 1'b0, IN_valid = 1'b0, IN_opDiv = 1'b0;
    logic [6:0]  IN_branchSqN = 7'd0, IN_sqN = 7'd0, IN_tagDst = 7'd0;
    logic [4:0]  IN_nmDst = 5'd0;
    logic [31:0] IN_srcA = 32'd0, IN_srcB = 32'd0;
    logic [31:0] DIV_result = 32'd0;
    logic [4:0]  DIV_flags = 5'd0;
    logic        WB_grant = 1'b0;
    logic        OUT_ready, DIV_start, DIV_opDiv, OUT_valid;
    logic [31:0] DIV_a, DIV_b, OUT_result;
    logic [4:0]  OUT_flags, OUT_nmDst;
    logic [6:0]  OUT_sqN, OUT_tagDst;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fpu_div_sched #(.LAT(LAT)) dut (
        .clk(clk), .rst(rst), .en(en),
        .IN_branchValid(IN_branchValid), .IN_branchSqN(IN_branchSqN),
        .IN_valid(IN_valid), .IN_opDiv(IN_opDiv), .IN_srcA(IN_srcA), .IN_srcB(IN_srcB),
        .IN_sqN(IN_sqN), .IN_tagDst(IN_tagDst), .IN_nmDst(IN_nmDst),
        .OUT_ready(OUT_ready), .DIV_start(DIV_start), .DIV_opDiv(DIV_opDiv),
        .DIV_a(DIV_a), .DIV_b(DIV_b), .DIV_result(DIV_result), .DIV_flags(DIV_flags),
        .WB_grant(WB_grant), .OUT_valid(OUT_valid), .OUT_result(OUT_result),
        .OUT_flags(OUT_flags), .OUT_sqN(OUT_sqN), .OUT_tagDst(OUT_tagDst),
        .OUT_nmDst(OUT_nmDst)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic sq(input logic bv, input logic [6:0] x, input logic [6:0] br);
        logic [6:0] d;
        d = x - br;
        return bv && ($signed(d) > 0);
    endfunction

    // Stand-in for the iterative core's arithmetic; one real fdiv case is pinned.
    function automatic logic [31:0] core_res(input logic op, input logic [31:0] a, input logic [31:0] b);
        if (op && a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
        return op ? ((a ^ {b[7:0], b[31:8]}) + 32'h1234) : ({a[30:0], a[31]} ^ 32'h5a5a5a5a);
    endfunction

    function automatic logic [4:0] core_flg(input logic op, input logic [31:0] a, input logic [31:0] b);
        return a[4:0] ^ b[9:5] ^ {4'b0, op};
    endfunction

    // Model: one pending uop issued at edge m_issue, result owed at edge m_issue+LAT.
    int          edge_cnt = 0;
    int          m_issue = 0;
    bit          m_inflight = 0, m_valid = 0;
    logic        m_op = 1'b0;
    logic [31:0] m_a = 32'd0, m_b = 32'd0, m_res = 32'd0;
    logic [6:0]  m_sqn = 7'd0, m_tag = 7'd0;
    logic [4:0]  m_nm = 5'd0, m_flg = 5'd0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_inflight = 0;
            m_valid    = 0;
        end else begin
            edge_cnt++;
            if (!m_inflight) begin
                if (en && IN_valid && !sq(IN_branchValid, IN_sqN, IN_branchSqN)) begin
                    m_inflight = 1;
                    m_issue    = edge_cnt;
                    m_op = IN_opDiv; m_a = IN_srcA; m_b = IN_srcB;
                    m_sqn = IN_sqN; m_tag = IN_tagDst; m_nm = IN_nmDst;
                end
            end else if (sq(IN_branchValid, m_sqn, IN_branchSqN)) begin
                m_inflight = 0;
                m_valid    = 0;
            end else if (!m_valid && edge_cnt == m_issue + LAT) begin
                m_valid = 1;
                m_res   = core_res(m_op, m_a, m_b);
                m_flg   = core_flg(m_op, m_a, m_b);
            end else if (m_valid && WB_grant) begin
                m_inflight = 0;
                m_valid    = 0;
            end
        end
    end

    // Core stand-in: the true result is on the bus only in the cycle before it is owed.
    always @(posedge clk) begin
        #2;
        if (m_inflight && !m_valid && edge_cnt == m_issue + LAT - 1) begin
            DIV_result = core_res(m_op, m_a, m_b);
            DIV_flags  = core_flg(m_op, m_a, m_b);
        end else begin
            DIV_result = $urandom;
            DIV_flags  = 5'($urandom);
        end
    end

    logic exp_start;
    always @(negedge clk) begin
        if (rst) begin
            exp_start = !m_inflight && en && IN_valid && !sq(IN_branchValid, IN_sqN, IN_branchSqN);
            chk("DIV_start", DIV_start, exp_start);
            chk("OUT_ready", OUT_ready, !m_inflight);
            chk("OUT_valid", OUT_valid, m_valid);
            if (exp_start) begin
                chk("DIV_a_in", DIV_a, IN_srcA);
                chk("DIV_b_in", DIV_b, IN_srcB);
                chk("DIV_op_in", DIV_opDiv, IN_opDiv);
            end else if (m_inflight) begin
                chk("DIV_a_lat", DIV_a, m_a);
                chk("DIV_b_lat", DIV_b, m_b);
                chk("DIV_op_lat", DIV_opDiv, m_op);
            end
            if (m_valid) begin
                chk("OUT_result", OUT_result, m_res);
                chk("OUT_flags", OUT_flags, m_flg);
                chk("OUT_sqN", OUT_sqN, m_sqn);
                chk("OUT_tagDst", OUT_tagDst, m_tag);
                chk("OUT_nmDst", OUT_nmDst, m_nm);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic present(input logic op, input logic [31:0] a, input logic [31:0] b,
                           input logic [6:0] sqn);
        IN_valid = 1'b1; IN_opDiv = op; IN_srcA = a; IN_srcB = b;
        IN_sqN = sqn; IN_tagDst = 7'(sqn + 7'd3); IN_nmDst = 5'(sqn);
    endtask

    task automatic drain();
        WB_grant = 1'b1;
        for (int i = 0; i < 4 * LAT && !OUT_ready; i++) tick(1);
        chk("drain_ready", OUT_ready, 1'b1);
        WB_grant = 1'b0;
    endtask

    initial begin
        en = 1'b1;
        IN_valid = 1'b1;
        #3;
        chk("rst_ready", OUT_ready, 1'b1);
        chk("rst_valid", OUT_valid, 1'b0);
        chk("rst_start", DIV_start, 1'b0);
        chk("rst_result", OUT_result, 32'd0);
        chk("rst_sqN", OUT_sqN, 7'd0);
        @(posedge clk); #1;
        rst = 1'b1; IN_valid = 1'b0;
        tick(1);

        // Basic fdiv 6.0 / 2.0 followed by a writeback stall
        present(1'b1, 32'h40C00000, 32'h40000000, 7'd5);
        @(negedge clk);
        chk("bas_start", DIV_start, 1'b1);
        chk("bas_a", DIV_a, 32'h40C00000);
        tick(1);
        IN_valid = 1'b0;
        tick(11);
        @(negedge clk);
        chk("bas_early", OUT_valid, 1'b0);
        tick(1);
        @(negedge clk);
        chk("bas_valid", OUT_valid, 1'b1);
        chk("bas_result", OUT_result, 32'h40400000);
        chk("bas_sqN", OUT_sqN, 7'd5);
        tick(2);
        @(negedge clk);
        chk("stall_valid", OUT_valid, 1'b1);
        chk("stall_result", OUT_result, 32'h40400000);
        tick(1);
        WB_grant = 1'b1;
        present(1'b0, 32'h3f800000, 32'h0, 7'd6);
        @(negedge clk);
        chk("wb_no_accept", DIV_start, 1'b0);
        tick(1);
        WB_grant = 1'b0; IN_valid = 1'b0;
        @(negedge clk);
        chk("wb_ready", OUT_ready, 1'b1);
        tick(1);

        // Mid-operation flush: older branch no effect, younger-than-branch uop squashed
        present(1'b1, 32'h41200000, 32'h40a00000, 7'd10);
        tick(1);
        IN_valid = 1'b0;
        tick(3);
        IN_branchValid = 1'b1; IN_branchSqN = 7'd12;
        tick(1);
        chk("flush_keep", OUT_ready, 1'b0);
        IN_branchSqN = 7'd8;
        tick(1);
        IN_branchValid = 1'b0;
        chk("flush_ready", OUT_ready, 1'b1);
        tick(LAT + 2);
        chk("flush_novalid", OUT_valid, 1'b0);

        // Wrap-around comparison
        present(1'b0, 32'h40800000, 32'h0, 7'd2);
        tick(1);
        IN_valid = 1'b0; IN_branchValid = 1'b1; IN_branchSqN = 7'd126;
        tick(1);
        IN_branchValid = 1'b0;
        chk("wrap_squash", OUT_ready, 1'b1);
        present(1'b0, 32'h40800000, 32'h0, 7'd126);
        tick(1);
        IN_valid = 1'b0; IN_branchValid = 1'b1; IN_branchSqN = 7'd2;
        tick(1);
        IN_branchValid = 1'b0;
        chk("wrap_keep", OUT_ready, 1'b0);
        drain();

        // Squashed offer in IDLE
        present(1'b1, 32'h1, 32'h2, 7'd20);
        IN_branchValid = 1'b1; IN_branchSqN = 7'd15;
        @(negedge clk);
        chk("sqoff_start", DIV_start, 1'b0);
        tick(1);
        IN_valid = 1'b0; IN_branchValid = 1'b0;
        chk("sqoff_ready", OUT_ready, 1'b1);

        // Async reset in DONE
        present(1'b1, 32'h12345678, 32'h9abcdef0, 7'd40);
        tick(1);
        IN_valid = 1'b0;
        tick(LAT);
        chk("ar_done", OUT_valid, 1'b1);
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        chk("ar_valid", OUT_valid, 1'b0);
        chk("ar_ready", OUT_ready, 1'b1);
        chk("ar_result", OUT_result, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("ar_release", OUT_ready, 1'b1);
        tick(1);

        // Randomized traffic, checked every cycle by the compare process
        for (int i = 0; i < 3000; i++) begin
            en             = ($urandom_range(0, 7) != 0);
            IN_valid       = $urandom_range(0, 1);
            IN_opDiv       = $urandom_range(0, 1);
            IN_srcA        = $urandom;
            IN_srcB        = $urandom;
            IN_sqN         = 7'($urandom);
            IN_tagDst      = 7'($urandom);
            IN_nmDst       = 5'($urandom);
            IN_branchValid = ($urandom_range(0, 15) == 0);
            IN_branchSqN   = 7'($urandom);
            WB_grant       = ($urandom_range(0, 2) != 0);
            tick(1);
        end
        IN_valid = 1'b0; IN_branchValid = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fpu_div_sched.md
FPU_DIV_SCHED -- requirements
Module: fpu_div_sched

Interface
REQ-001 SHALL have parameter LAT, default 12: fixed cycle count from DIV_start to valid DIV_result; legal range 2..63.
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  issue enable.
- IN_branchValid  in  1  mispredict flush this cycle.
- IN_branchSqN  in  7  sequence number of the mispredicted branch.
- IN_valid  in  1  divide/sqrt uop offered.
- IN_opDiv  in  1  1 = fdiv, 0 = fsqrt.
- IN_srcA  in  32  operand A, IEEE single.
- IN_srcB  in  32  operand B; ignored for sqrt.
- IN_sqN  in  7  uop sequence number.
- IN_tagDst  in  7  destination physical tag.
- IN_nmDst  in  5  destination architectural register.
- OUT_ready  out  1  scheduler can accept a uop.
- DIV_start  out  1  one-cycle start pulse to the iterative core.
- DIV_opDiv  out  1  operation to the core.
- DIV_a  out  32  operand A to the core.
- DIV_b  out  32  operand B to the core.
- DIV_result  in  32  core result, valid LAT cycles after start.
- DIV_flags  in  5  core exception flags, same timing as DIV_result.
- WB_grant  in  1  writeback port granted this cycle.
- OUT_valid  out  1  result pending for writeback.
- OUT_result  out  32  result.
- OUT_flags  out  5  exception flags.
- OUT_sqN  out  7  sequence number.
- OUT_tagDst  out  7  destination tag.
- OUT_nmDst  out  5  destination register.

Function
REQ-003 SHALL implement states IDLE, BUSY and DONE; exactly one uop in flight.
REQ-004 SHALL define squash(x) as IN_branchValid && signed 7-bit (x - IN_branchSqN) > 0, i.e. wrap-around comparison.
REQ-005 SHALL drive OUT_ready = 1 only in IDLE.
REQ-006 SHALL accept a uop in IDLE when en && IN_valid && !squash(IN_sqN): latch all IN_ fields, assert DIV_start for that single cycle, load counter with LAT-1, go to BUSY.
REQ-007 SHALL drive DIV_opDiv, DIV_a and DIV_b combinationally from the IN_ fields in the accept cycle, and from the latched fields otherwise.
REQ-008 SHALL drop an offered uop with squash(IN_sqN) = 1: no start pulse and the state stays IDLE.
REQ-009 In BUSY, SHALL decrement the counter each cycle; at counter 0, SHALL latch DIV_result and DIV_flags into OUT_result and OUT_flags and go to DONE.
REQ-010 SHALL drive OUT_valid = 1 only in DONE; OUT_sqN, OUT_tagDst and OUT_nmDst SHALL come from the latched uop.
REQ-011 In DONE with WB_grant = 1, SHALL go to IDLE the next cycle; a new uop SHALL NOT be accepted in that same cycle.
REQ-012 In DONE with WB_grant = 0, SHALL hold all OUT_ signals stable.
REQ-013 In BUSY or DONE, squash(latched sqN) SHALL force IDLE next cycle with OUT_valid low; this takes priority over counter expiry and over WB_grant.
REQ-014 SHALL issue no DIV_start while BUSY; the core is assumed idle only after LAT cycles.
REQ-015 SHALL ignore en outside IDLE; an in-flight operation continues when en = 0.

Reset
REQ-016 While rst = 0, SHALL asynchronously force the following: state IDLE; counter 0; DIV_start 0; OUT_valid 0; OUT_result, OUT_flags, OUT_sqN, OUT_tagDst and OUT_nmDst 0.
REQ-017 A reset during BUSY or DONE SHALL discard the uop; the first cycle after rst rises SHALL show OUT_ready = 1.

Verification
REQ-018 SHALL cover these directed scenarios:
- Basic fdiv: LAT=12; accept fdiv 6.0/2.0 (sqN=5) at cycle 0; DIV_result=0x40400000 presented -> DIV_start only at cycle 0; OUT_valid=1 from cycle 12 with OUT_result=0x40400000 and OUT_sqN=5.
- Writeback stall: hold WB_grant=0 for 3 cycles in DONE -> outputs stable; grant in the 4th cycle -> IDLE next cycle, OUT_ready=1.
- Mid-operation flush: in-flight sqN=10; branch sqN=8 at cycle 4 -> IDLE at cycle 5, no OUT_valid; branch sqN=12 -> no effect.
- Wrap-around: in-flight sqN=2, branch sqN=126 -> squashed (2-126 = +4); sqN=126 vs branch 2 -> kept.
- Squashed offer: IN_valid with sqN=20 while branch sqN=15 is flushing in IDLE -> no DIV_start, stays IDLE.
- Async reset in DONE: pull rst low mid-cycle -> OUT_valid=0 immediately; OUT_ready=1 after release.
